vpu_bg_line_renderer: RTL and testbench



---
 rtl/vpu_bg_line_renderer.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_vpu_bg_line_renderer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_bg_line_renderer.sv
// Renders one scanline of tile-mapped BG layers into a double-buffered line
// buffer; the display side reads the previously completed line meanwhile.
module vpu_bg_line_renderer #(
  parameter int NUM_LAYERS  = 4,
  parameter int LINE_W      = 320,
  parameter int TILE_ADDR_W = 16,
  parameter int PAL_ADDR_W  = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [7:0]               y_i,
  input  logic [32*NUM_LAYERS-1:0] cfg0_i,
  input  logic [32*NUM_LAYERS-1:0] cfg1_i,
  input  logic [31:0]              backdrop_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     map_en_o,
  output logic [14:0]              map_addr_o,
  input  logic [15:0]              map_data_i,
  output logic                     tile_en_o,
  output logic [TILE_ADDR_W-1:0]   tile_addr_o,
  input  logic [7:0]               tile_data_i,
  output logic                     pal_en_o,
  output logic [PAL_ADDR_W-1:0]    pal_addr_o,
  input  logic [31:0]              pal_data_i,
  input  logic [8:0]               rd_x_i,
  output logic [31:0]              rd_color_o
);

  localparam int XW = $clog2(LINE_W);
  localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int AW = $clog2(2 * LINE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_RUN,
    S_CLEAR,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [LW-1:0] firstLayer_q, firstLayer_d;
  logic [1:0]    drainCnt_q, drainCnt_d;
  logic          frontBank_q;
  logic          frontValid_q;
  logic [31:0]   rdColor_q;

  // Per-layer configuration fields captured when a line is accepted
  logic [7:0]            y_q;
  logic [31:0]           backdrop_q;
  logic [NUM_LAYERS-1:0] layerEn_q, hflip_q, vflip_q, palMode_q;
  logic [1:0]            tileSize_q [NUM_LAYERS];
  logic [8:0]            scrollX_q  [NUM_LAYERS];
  logic [7:0]            scrollY_q  [NUM_LAYERS];
  logic [3:0]            mapBank_q  [NUM_LAYERS];
  logic [1:0]            palBank_q  [NUM_LAYERS];
  logic [3:0]            palNo_q    [NUM_LAYERS];

  logic [31:0] lineBuf [2*LINE_W];

  logic          s1Valid_q, s2Valid_q, s3Valid_q;
  logic [XW-1:0] s1X_q, s2X_q, s3X_q;
  logic [5:0]    s1Px_q, s1Py_q;
  logic [1:0]    s1Ts_q;
  logic          s1PalMode_q, s2PalMode_q;
  logic [1:0]    s1PalBank_q, s2PalBank_q;
  logic [3:0]    s1PalNo_q, s2PalNo_q;
  logic          s1First_q, s2First_q;
  logic          s3Transp_q;
  logic [31:0]   s3Dst_q;

  logic          anyEn, nextFound;
  logic [LW-1:0] firstEn, nextEn;
  logic [1:0]    ts;
  logic [8:0]    tMask, pxRaw, px;
  logic [7:0]    pyRaw, py;
  logic [2:0]    shAmt;
  logic [10:0]   mapIdx;
  logic [5:0]    tMaskS1, pxT, pyT;
  logic          transp;
  logic [7:0]    srcA;
  logic [31:0]   blendPix;
  logic          cfgUnused;

  function automatic logic [AW-1:0] bufIdx(input logic bank, input logic [XW-1:0] xi);
    return bank ? (AW'(LINE_W) + AW'(xi)) : AW'(xi);
  endfunction

  function automatic logic [7:0] mixCh(input logic [7:0] d, input logic [7:0] s,
                                      input logic [7:0] a);
    logic [15:0] sum;
    sum = {8'b0, d} * (16'd255 - {8'b0, a}) + {8'b0, s} * {8'b0, a};
    return 8'(sum >> 8);
  endfunction

  // Reserved configuration bits are intentionally ignored
  always_comb begin
    cfgUnused = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      cfgUnused = cfgUnused ^ (^cfg0_i[32*i+28 +: 3]) ^ (^cfg0_i[32*i+17 +: 7])
                            ^ (^cfg1_i[32*i+28 +: 4]) ^ (^cfg1_i[32*i+7 +: 17]);
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && start_i) begin
      y_q        <= y_i;
      backdrop_q <= backdrop_i;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        layerEn_q[i]  <= cfg0_i[32*i+31];
        hflip_q[i]    <= cfg0_i[32*i+27];
        vflip_q[i]    <= cfg0_i[32*i+26];
        tileSize_q[i] <= cfg0_i[32*i+24 +: 2];
        scrollX_q[i]  <= cfg0_i[32*i+8 +: 9];
        scrollY_q[i]  <= cfg0_i[32*i +: 8];
        mapBank_q[i]  <= cfg1_i[32*i+24 +: 4];
        palMode_q[i]  <= cfg1_i[32*i+6];
        palBank_q[i]  <= cfg1_i[32*i+4 +: 2];
        palNo_q[i]    <= cfg1_i[32*i +: 4];
      end
    end
  end

  // Lowest enabled layer overall, and lowest enabled layer above the current one
  always_comb begin
    anyEn     = 1'b0;
    firstEn   = '0;
    nextFound = 1'b0;
    nextEn    = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layerEn_q[i]) begin
        anyEn   = 1'b1;
        firstEn = LW'(i);
        if (i > int'(layer_q)) begin
          nextFound = 1'b1;
          nextEn    = LW'(i);
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    layer_d      = layer_q;
    firstLayer_d = firstLayer_q;
    drainCnt_d   = drainCnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_SETUP;
      end
      S_SETUP: begin
        x_d          = '0;
        drainCnt_d   = '0;
        layer_d      = firstEn;
        firstLayer_d = firstEn;
        state_d      = anyEn ? S_RUN : S_CLEAR;
      end
      S_RUN: begin
        if (x_q == XW'(LINE_W - 1)) begin
          x_d = '0;
          if (nextFound) layer_d = nextEn;
          else           state_d = S_DRAIN;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (x_q == XW'(LINE_W - 1)) begin
          x_d     = '0;
          state_d = S_DRAIN;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      S_DRAIN: begin
        drainCnt_d = drainCnt_q + 1'b1;
        if (drainCnt_q == 2'd3) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Banks swap on the edge that enters DONE, after the last pipeline write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      layer_q      <= '0;
      firstLayer_q <= '0;
      drainCnt_q   <= '0;
      frontBank_q  <= 1'b0;
      frontValid_q <= 1'b0;
      s1Valid_q    <= 1'b0;
      s2Valid_q    <= 1'b0;
      s3Valid_q    <= 1'b0;
      rdColor_q    <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      layer_q      <= layer_d;
      firstLayer_q <= firstLayer_d;
      drainCnt_q   <= drainCnt_d;
      s1Valid_q    <= (state_q == S_RUN);
      s2Valid_q    <= s1Valid_q;
      s3Valid_q    <= s2Valid_q;
      if (state_q == S_DRAIN && drainCnt_q == 2'd3) begin
        frontBank_q  <= ~frontBank_q;
        frontValid_q <= 1'b1;
      end
      if (frontValid_q && (32'(rd_x_i) < LINE_W))
        rdColor_q <= lineBuf[bufIdx(frontBank_q, XW'(rd_x_i))];
      else
        rdColor_q <= '0;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign rd_color_o = rdColor_q;

  // Flips mirror within a tile, which for power-of-two tiles is an XOR with T-1
  always_comb begin
    ts         = tileSize_q[layer_q];
    tMask      = (9'd8 << ts) - 9'd1;
    pxRaw      = 9'(x_q) + scrollX_q[layer_q];
    pyRaw      = y_q + scrollY_q[layer_q];
    px         = hflip_q[layer_q] ? (pxRaw ^ tMask) : pxRaw;
    py         = vflip_q[layer_q] ? (pyRaw ^ tMask[7:0]) : pyRaw;
    shAmt      = 3'd3 + {1'b0, ts};
    mapIdx     = 11'(((32'(py) >> shAmt) * (32'd64 >> ts)) + (32'(px) >> shAmt));
    map_en_o   = (state_q == S_RUN);
    map_addr_o = map_en_o ? {mapBank_q[layer_q], mapIdx} : '0;
  end

  always_comb begin
    tMaskS1     = 6'((7'd8 << s1Ts_q) - 7'd1);
    pxT         = s1Px_q & tMaskS1;
    pyT         = s1Py_q & tMaskS1;
    tile_en_o   = s1Valid_q;
    tile_addr_o = TILE_ADDR_W'((((32'(map_data_i) << {s1Ts_q, 1'b0})
                                 + ((32'(pyT) >> 3) << s1Ts_q)
                                 + (32'(pxT) >> 3)) * 32'd64)
                               + 32'({pyT[2:0], pxT[2:0]}));
  end

  always_comb begin
    pal_en_o = s2Valid_q;
    if (s2PalMode_q) begin
      pal_addr_o = PAL_ADDR_W'({s2PalBank_q, s2PalNo_q, tile_data_i[3:0]});
      transp     = (tile_data_i[3:0] == 4'd0);
    end else begin
      pal_addr_o = PAL_ADDR_W'({s2PalBank_q, tile_data_i});
      transp     = (tile_data_i == 8'd0);
    end
  end

  always_comb begin
    srcA     = pal_data_i[31:24];
    blendPix = s3Dst_q;
    if (!s3Transp_q && srcA == 8'hFF) begin
      blendPix = pal_data_i;
    end else if (!s3Transp_q && srcA != 8'h00) begin
      blendPix[31:24] = 8'(({1'b0, s3Dst_q[31:24]} + {1'b0, srcA}) >> 1);
      blendPix[23:16] = mixCh(s3Dst_q[23:16], pal_data_i[23:16], srcA);
      blendPix[15:8]  = mixCh(s3Dst_q[15:8],  pal_data_i[15:8],  srcA);
      blendPix[7:0]   = mixCh(s3Dst_q[7:0],   pal_data_i[7:0],   srcA);
    end
  end

  // The first enabled layer blends over the backdrop, later ones over the back bank
  always_ff @(posedge clk) begin
    s1X_q       <= x_q;
    s1Px_q      <= px[5:0];
    s1Py_q      <= py[5:0];
    s1Ts_q      <= ts;
    s1PalMode_q <= palMode_q[layer_q];
    s1PalBank_q <= palBank_q[layer_q];
    s1PalNo_q   <= palNo_q[layer_q];
    s1First_q   <= (layer_q == firstLayer_q);
    s2X_q       <= s1X_q;
    s2PalMode_q <= s1PalMode_q;
    s2PalBank_q <= s1PalBank_q;
    s2PalNo_q   <= s1PalNo_q;
    s2First_q   <= s1First_q;
    s3X_q       <= s2X_q;
    s3Transp_q  <= transp;
    s3Dst_q     <= s2First_q ? backdrop_q : lineBuf[bufIdx(~frontBank_q, s2X_q)];
  end

  always_ff @(posedge clk) begin
    if (rst_n && s3Valid_q)
      lineBuf[bufIdx(~frontBank_q, s3X_q)] <= blendPix;
    else if (rst_n && state_q == S_CLEAR)
      lineBuf[bufIdx(~frontBank_q, x_q)] <= backdrop_q;
  end

endmodule

// File: tb/tb_vpu_bg_line_renderer.sv
// Self-checking bench for vpu_bg_line_renderer: RAM models, cycle-accurate
// latency checks and a scoreboard on the display read port.
module tb_vpu_bg_line_renderer;

  localparam int NL = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      y = 8'd0;
  logic [32*NL-1:0] cfg0 = '0;
  logic [32*NL-1:0] cfg1 = '0;
  logic [31:0]     backdrop = 32'd0;
  logic            busy, done;
  logic            map_en, tile_en, pal_en;
  logic [14:0]     map_addr;
  logic [15:0]     tile_addr;
  logic [9:0]      pal_addr;
  logic [15:0]     map_data = 16'd0;
  logic [7:0]      tile_data = 8'd0;
  logic [31:0]     pal_data = 32'd0;
  logic [8:0]      rd_x = 9'd0;
  logic [31:0]     rd_color;

  int assertCount = 0;
  int failCount   = 0;

  logic [15:0] mapConst = 16'd0;
  logic [7:0]  tileConst = 8'd0;
  logic [31:0] palMem [1024];
  logic [31:0] expQ [$];
  logic [31:0] gotQ [$];
  logic [8:0]  xs [6] = '{9'd0, 9'd1, 9'd7, 9'd160, 9'd318, 9'd319};

  vpu_bg_line_renderer dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .y_i(y),
    .cfg0_i(cfg0), .cfg1_i(cfg1), .backdrop_i(backdrop),
    .busy_o(busy), .done_o(done),
    .map_en_o(map_en), .map_addr_o(map_addr), .map_data_i(map_data),
    .tile_en_o(tile_en), .tile_addr_o(tile_addr), .tile_data_i(tile_data),
    .pal_en_o(pal_en), .pal_addr_o(pal_addr), .pal_data_i(pal_data),
    .rd_x_i(rd_x), .rd_color_o(rd_color)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (map_en)  map_data  <= mapConst;
    if (tile_en) tile_data <= tileConst;
    if (pal_en)  pal_data  <= palMem[pal_addr];
  end

  function automatic logic [31:0] mkCfg0(input logic en, input logic hf, input logic vf,
                                         input logic [1:0] tsz, input logic [8:0] sx,
                                         input logic [7:0] sy);
    return {en, 3'b0, hf, vf, tsz, 7'b0, sx, sy};
  endfunction

  function automatic logic [31:0] mkCfg1(input logic [3:0] bank, input logic mode,
                                         input logic [1:0] pb, input logic [3:0] pn);
    return {4'b0, bank, 17'b0, mode, pb, pn};
  endfunction

  function automatic logic [31:0] blendModel(input logic [31:0] dst, input logic [31:0] src,
                                             input logic tr);
    int a, r, g, b, al;
    a = int'(src[31:24]);
    if (tr || a == 0) return dst;
    if (a == 255) return src;
    r  = (int'(dst[23:16]) * (255 - a) + int'(src[23:16]) * a) / 256;
    g  = (int'(dst[15:8])  * (255 - a) + int'(src[15:8])  * a) / 256;
    b  = (int'(dst[7:0])   * (255 - a) + int'(src[7:0])   * a) / 256;
    al = (int'(dst[31:24]) + a) / 2;
    return {al[7:0], r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic runLine(input int pulseAt, output int cycles, output logic [14:0] fMap,
                         output logic [15:0] fTile, output logic [9:0] fPal,
                         output logic busyStart, output logic busyDone, output logic busyEnd);
    bit gm, gt, gp;
    gm = 0; gt = 0; gp = 0;
    fMap = '1; fTile = '1; fPal = '1;
    cycles = -1; busyDone = 1'b0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0; busyStart = busy;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge clk); #1;
      start = (c == pulseAt);
      if (map_en && !gm)  begin gm = 1; fMap  = map_addr;  end
      if (tile_en && !gt) begin gt = 1; fTile = tile_addr; end
      if (pal_en && !gp)  begin gp = 1; fPal  = pal_addr;  end
      if (done) begin cycles = c; busyDone = busy; break; end
    end
    start = 1'b0;
    @(posedge clk); #1; busyEnd = busy;
  endtask

  task automatic samplePixels();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) gotQ.push_back(rd_color);
      rd_x = xs[i];
    end
    @(negedge clk); gotQ.push_back(rd_color);
  endtask

  task automatic test_reset();
    logic [31:0] e, g;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    assertCount++;
    if ({busy, done, map_en, tile_en, pal_en} !== 5'b0) begin
      failCount++;
      $display("[TB] FAIL reset.ctrl: got %b expected 00000", {busy, done, map_en, tile_en, pal_en});
    end
    for (int i = 0; i < 6; i++) expQ.push_back(32'h0);
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL reset.rd_color: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_single_layer();
    int cyc; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    logic [31:0] e, g;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0] = mkCfg0(1, 0, 0, 2'd0, 9'd0, 8'd0);
    cfg1[31:0] = mkCfg1(4'd3, 0, 2'd0, 4'd0);
    mapConst = 16'd1; tileConst = 8'd5; palMem[5] = 32'hFF112233;
    backdrop = 32'h12345678; y = 8'd0;
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (cyc !== 325) begin failCount++; $display("[TB] FAIL single.latency: got %0d expected 325", cyc); end
    assertCount++;
    if (fm !== 15'h1800) begin failCount++; $display("[TB] FAIL single.map_addr: got %h expected 1800", fm); end
    assertCount++;
    if (ft !== 16'd64) begin failCount++; $display("[TB] FAIL single.tile_addr: got %0d expected 64", ft); end
    assertCount++;
    if (fp !== 10'd5) begin failCount++; $display("[TB] FAIL single.pal_addr: got %0d expected 5", fp); end
    assertCount++;
    if ({bs, bd, be} !== 3'b110) begin failCount++; $display("[TB] FAIL single.busy: got %b expected 110", {bs, bd, be}); end
    for (int i = 0; i < 6; i++) expQ.push_back(blendModel(backdrop, 32'hFF112233, 1'b0));
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL single.pixel: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_all_disabled();
    int cyc; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    logic [31:0] e, g;
    cfg0 = '0; cfg1 = '0; backdrop = 32'hFF000080;
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (cyc !== 325) begin failCount++; $display("[TB] FAIL clear.latency: got %0d expected 325", cyc); end
    assertCount++;
    if (fm !== 15'h7FFF) begin failCount++; $display("[TB] FAIL clear.no_map_read: got %h expected 7fff", fm); end
    for (int i = 0; i < 6; i++) expQ.push_back(32'hFF000080);
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL clear.pixel: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_two_layers();
    int cyc; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    logic [31:0] e, g;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0]  = mkCfg0(1, 0, 0, 2'd0, 9'd0, 8'd0);
    cfg0[95:64] = mkCfg0(1, 0, 0, 2'd0, 9'd0, 8'd0);
    cfg1[31:0]  = mkCfg1(4'd0, 0, 2'd0, 4'd0);
    cfg1[95:64] = mkCfg1(4'd0, 0, 2'd1, 4'd0);
    mapConst = 16'd1; tileConst = 8'd5;
    palMem[5] = 32'hFF0000FF; palMem[10'h105] = 32'h80FF0000;
    backdrop = 32'h00000000;
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (cyc !== 645) begin failCount++; $display("[TB] FAIL two.latency: got %0d expected 645", cyc); end
    for (int i = 0; i < 6; i++)
      expQ.push_back(blendModel(blendModel(backdrop, 32'hFF0000FF, 1'b0), 32'h80FF0000, 1'b0));
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL two.pixel: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_transparent();
    int cyc; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    logic [31:0] e, g;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0] = mkCfg0(1, 0, 0, 2'd0, 9'd0, 8'd0);
    mapConst = 16'd1; tileConst = 8'd0; palMem[0] = 32'hFFFFFFFF;
    backdrop = 32'hFF00FF00;
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (cyc !== 325) begin failCount++; $display("[TB] FAIL transp.latency: got %0d expected 325", cyc); end
    for (int i = 0; i < 6; i++) expQ.push_back(blendModel(backdrop, 32'hFFFFFFFF, 1'b1));
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL transp.pixel: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_scroll_vflip();
    int cyc; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0] = mkCfg0(1, 0, 1, 2'd0, 9'd511, 8'd0);
    mapConst = 16'd1; tileConst = 8'd5; y = 8'd3;
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    y = 8'd0;
    assertCount++;
    if (fm !== 15'd63) begin failCount++; $display("[TB] FAIL scroll.map_addr: got %0d expected 63", fm); end
    assertCount++;
    if (ft !== 16'd103) begin failCount++; $display("[TB] FAIL scroll.tile_addr: got %0d expected 103", ft); end
  endtask

  task automatic test_hflip_palmode();
    int cyc; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    logic [31:0] e, g;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0] = mkCfg0(1, 1, 0, 2'd1, 9'd0, 8'd0);
    cfg1[31:0] = mkCfg1(4'd0, 1, 2'd2, 4'hA);
    mapConst = 16'd1; tileConst = 8'd5; palMem[677] = 32'hFFABCDEF;
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (fm !== 15'd0) begin failCount++; $display("[TB] FAIL hflip.map_addr: got %0d expected 0", fm); end
    assertCount++;
    if (ft !== 16'd327) begin failCount++; $display("[TB] FAIL hflip.tile_addr: got %0d expected 327", ft); end
    assertCount++;
    if (fp !== 10'd677) begin failCount++; $display("[TB] FAIL palmode.pal_addr: got %0d expected 677", fp); end
    for (int i = 0; i < 6; i++) expQ.push_back(32'hFFABCDEF);
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL palmode.pixel: got %h expected %h", g, e); end
    end
  endtask

  task automatic test_back_to_back();
    int cyc, extra; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0] = mkCfg0(1, 0, 0, 2'd0, 9'd0, 8'd0);
    mapConst = 16'd1; tileConst = 8'd5;
    runLine(100, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (cyc !== 325) begin failCount++; $display("[TB] FAIL b2b.latency: got %0d expected 325", cyc); end
    extra = 0;
    repeat (400) begin @(posedge clk); #1; if (done || busy) extra++; end
    assertCount++;
    if (extra !== 0) begin failCount++; $display("[TB] FAIL b2b.extra_activity: got %0d expected 0", extra); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, dones; logic [14:0] fm; logic [15:0] ft; logic [9:0] fp; logic bs, bd, be;
    logic [31:0] e, g;
    cfg0 = '0; cfg1 = '0;
    cfg0[31:0] = mkCfg0(1, 0, 0, 2'd0, 9'd0, 8'd0);
    mapConst = 16'd1; tileConst = 8'd5; palMem[5] = 32'hFF445566;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (50) @(posedge clk);
    #1; rst_n = 1'b0;
    @(posedge clk); #1;
    assertCount++;
    if ({busy, done, map_en} !== 3'b000) begin
      failCount++; $display("[TB] FAIL abort.ctrl: got %b expected 000", {busy, done, map_en});
    end
    rst_n = 1'b1;
    dones = 0;
    repeat (400) begin @(posedge clk); #1; if (done) dones++; end
    assertCount++;
    if (dones !== 0) begin failCount++; $display("[TB] FAIL abort.done_count: got %0d expected 0", dones); end
    for (int i = 0; i < 6; i++) expQ.push_back(32'h0);
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL abort.front: got %h expected %h", g, e); end
    end
    runLine(0, cyc, fm, ft, fp, bs, bd, be);
    assertCount++;
    if (cyc !== 325) begin failCount++; $display("[TB] FAIL abort.recover_latency: got %0d expected 325", cyc); end
    for (int i = 0; i < 6; i++) expQ.push_back(32'hFF445566);
    samplePixels();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); g = (gotQ.size() > 0) ? gotQ.pop_front() : 32'hx;
      assertCount++;
      if (g !== e) begin failCount++; $display("[TB] FAIL abort.recover_pixel: got %h expected %h", g, e); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) palMem[i] = 32'h0;
    $display("[TB] starting vpu_bg_line_renderer bench");
    test_reset();
    test_single_layer();
    test_all_disabled();
    test_two_layers();
    test_transparent();
    test_scroll_vflip();
    test_hflip_palmode();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
